// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants and FSM state type for conv-layer line buffers
// Purpose: default activation width and per-layer geometry used as parameter
//   defaults by conv_pool_line_buffer, plus the buffer FSM state encoding.
// Ports: none (package).
package conv_pkg;

  localparam int CONV_DATA_W     = 8;
  localparam int CONV_ROW_LEN    = 24;
  localparam int CONV_ROWS_TOTAL = 24;
  localparam int CONV_POOL_K     = 2;
  localparam int CONV_BANK_AW    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } lb_state_e;

endpackage

// File: rtl/line_buf_ram.sv
// rtl/line_buf_ram.sv - simple dual-port RAM with registered read for the line buffer
// Purpose: storage for both ping-pong banks; bank select is the address MSB.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-low reset (read register only, array is not cleared)
//   we    in  write enable          waddr in  write address   wdata in  write data
//   re    in  read enable           raddr in  read address    rdata out registered read data
module line_buf_ram #(
  parameter int DATA_W = 8,
  parameter int AW     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv_pool_line_buffer.sv
// rtl/conv_pool_line_buffer.sv - ping-pong band buffer between a conv layer and ReLU/pool
// Purpose: collects POOL_K rows per bank in two banks, flags full bands to the
//   consumer and holds off the producer while the next bank is unreleased.
// Optional feature: LINE_BUF_STATS_EN adds stall_cycles (saturating stall counter).
// Ports:
//   clk, rst (async active-low)       start          in  begin a feature map (IDLE only)
//   wr_valid/wr_ready/wr_data         producer handshake, raster order
//   band_ready     out read bank holds a full band
//   rd_en/rd_addr  in  read strobe and offset in read bank; rd_data out one cycle later
//   rd_done        in  consumer releases the read bank
//   write_complete out whole map written      map_done out pulse on last band release
//   err_overflow   out sticky: write attempted in IDLE
//   stall_cycles   out [15:0] (LINE_BUF_STATS_EN only)
module conv_pool_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W     = CONV_DATA_W,
  parameter int ROW_LEN    = CONV_ROW_LEN,
  parameter int ROWS_TOTAL = CONV_ROWS_TOTAL,
  parameter int POOL_K     = CONV_POOL_K,
  parameter int BANK_AW    = CONV_BANK_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               band_ready,
  input  logic               rd_en,
  input  logic [BANK_AW-1:0] rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               rd_done,
  output logic               write_complete,
  output logic               map_done,
  output logic               err_overflow
`ifdef LINE_BUF_STATS_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int BAND  = POOL_K * ROW_LEN;
  localparam int TOTAL = ROWS_TOTAL * ROW_LEN;
  localparam int PTR_W = (BAND > 1) ? $clog2(BAND) : 1;
  localparam int CNT_W = $clog2(TOTAL + 1);

  lb_state_e        state, state_d;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] wr_cnt;
  logic             wr_bank, rd_bank;
  logic [1:0]       bank_valid, bank_valid_d;
  logic             wr_fire, band_fill, last_write, release_fire;

  // wr_ready and band_ready are decoded from registered flags only, so a
  // release shows up as wr_ready the cycle after rd_done.
  assign wr_ready     = (state == ST_FILL) && !bank_valid[wr_bank];
  assign wr_fire      = wr_valid && wr_ready;
  assign band_fill    = wr_fire && (wr_ptr == PTR_W'(BAND - 1));
  assign last_write   = wr_fire && (wr_cnt == CNT_W'(TOTAL - 1));
  assign band_ready   = bank_valid[rd_bank];
  assign release_fire = rd_done && band_ready;

  // Fill and release always target different banks (a full bank blocks
  // writes), so both updates can be applied in the same cycle.
  always_comb begin
    bank_valid_d = bank_valid;
    if (state == ST_IDLE && start) bank_valid_d = 2'b00;
    if (band_fill) bank_valid_d[wr_bank] = 1'b1;
    if (release_fire) bank_valid_d[rd_bank] = 1'b0;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (start) state_d = ST_FILL;
      ST_FILL:  if (last_write) state_d = ST_DRAIN;
      // Last band: releasing the read bank while the other bank is empty.
      ST_DRAIN: if (release_fire && !bank_valid[!rd_bank]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else state <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr         <= '0;
      wr_cnt         <= '0;
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      bank_valid     <= 2'b00;
      write_complete <= 1'b0;
      map_done       <= 1'b0;
      err_overflow   <= 1'b0;
    end else begin
      bank_valid <= bank_valid_d;
      map_done   <= 1'b0;
      if (state == ST_IDLE) begin
        if (wr_valid) err_overflow <= 1'b1;
        if (start) begin
          wr_ptr         <= '0;
          wr_cnt         <= '0;
          wr_bank        <= 1'b0;
          rd_bank        <= 1'b0;
          write_complete <= 1'b0;
        end
      end
      // wr_cnt stops at TOTAL because the FSM leaves FILL on the last write.
      if (wr_fire) begin
        wr_cnt <= wr_cnt + CNT_W'(1);
        if (band_fill) begin
          wr_ptr  <= '0;
          wr_bank <= !wr_bank;
        end else begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
      end
      if (last_write) write_complete <= 1'b1;
      if (release_fire) rd_bank <= !rd_bank;
      if (state == ST_DRAIN && state_d == ST_IDLE) begin
        map_done       <= 1'b1;
        write_complete <= 1'b0;
      end
    end
  end

`ifdef LINE_BUF_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cycles <= '0;
    else if (state == ST_IDLE && start) stall_cycles <= '0;
    else if (state == ST_FILL && wr_valid && !wr_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

  line_buf_ram #(
    .DATA_W (DATA_W),
    .AW     (BANK_AW + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_fire),
    .waddr ({wr_bank, BANK_AW'(wr_ptr)}),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr ({rd_bank, rd_addr}),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_conv_pool_line_buffer.sv
// tb/tb_conv_pool_line_buffer.sv - scoreboard bench for conv_pool_line_buffer
module tb_conv_pool_line_buffer;

  logic       clk = 1'b0;
  logic       rst, start, wr_valid, wr_ready, band_ready, rd_en, rd_done;
  logic [7:0] wr_data, rd_data;
  logic [5:0] rd_addr;
  logic       write_complete, map_done, err_overflow;
`ifdef LINE_BUF_STATS_EN
  logic [15:0] stall_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } rd_exp_t;
  rd_exp_t exp_q[$];
  logic    rd_vld_q = 1'b0;

  always #5 clk = ~clk;

  conv_pool_line_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_data        (wr_data),
    .band_ready     (band_ready),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .rd_done        (rd_done),
    .write_complete (write_complete),
    .map_done       (map_done),
    .err_overflow   (err_overflow)
`ifdef LINE_BUF_STATS_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  function automatic logic [7:0] pat(input int k, input int seed);
    return 8'((k * 5 + seed) & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Read monitor: rd_data must carry the expected sample exactly one cycle after rd_en.
  always @(posedge clk) rd_vld_q <= rd_en;

  always @(negedge clk) begin
    if (rd_vld_q) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got %0h expected no read", rd_data);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        check($sformatf("rd_data[%0d]", e.addr), 32'(rd_data), 32'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [7:0] d, input logic done);
    int n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    rd_done  = done;
    while (!wr_ready && n < 100) begin
      tick();
      n++;
    end
    if (!wr_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL write_timeout: got wr_ready=0 expected 1 within 100 cycles");
    end
    tick();
    rd_done = 1'b0;
  endtask

  task automatic read_chk(input int a, input logic [7:0] d);
    rd_en   = 1'b1;
    rd_addr = 6'(a);
    exp_q.push_back('{a, d});
    tick();
    rd_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; start = 1'b0; wr_valid = 1'b0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
    repeat (3) tick();
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_band_ready", 32'(band_ready), 0);
    check("rst_write_complete", 32'(write_complete), 0);
    check("rst_map_done", 32'(map_done), 0);
    check("rst_err_overflow", 32'(err_overflow), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b1;
    tick();

    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("err_overflow_idle", 32'(err_overflow), 1);
    check("wr_ready_idle", 32'(wr_ready), 0);

    pulse_start();
    check("wr_ready_fill", 32'(wr_ready), 1);
    for (int k = 0; k < 48; k++) begin
      write_one(pat(k, 0), 1'b0);
      if (k == 46) check("band_ready_w47", 32'(band_ready), 0);
    end
    wr_valid = 1'b0;
    check("band_ready_w48", 32'(band_ready), 1);
    check("wr_ready_w48", 32'(wr_ready), 1);

    for (int a = 0; a < 48; a++) read_chk(a, pat(a, 0));

    for (int k = 48; k < 96; k++) write_one(pat(k, 0), 1'b0);
    wr_valid = 1'b0;
    check("wr_ready_w96", 32'(wr_ready), 0);
    check("band_ready_w96", 32'(band_ready), 1);

    // Producer stalls 10 cycles; rd_done lands on the 10th.
    wr_valid = 1'b1;
    wr_data  = pat(96, 0);
    repeat (9) tick();
    check("wr_ready_stalled", 32'(wr_ready), 0);
    rd_done = 1'b1;
    tick();
    rd_done  = 1'b0;
    wr_valid = 1'b0;
    check("wr_ready_after_done", 32'(wr_ready), 1);
    check("band_ready_bank1", 32'(band_ready), 1);
`ifdef LINE_BUF_STATS_EN
    check("stall_cycles_10", 32'(stall_cycles), 10);
`endif

    read_chk(0, pat(48, 0));
    read_chk(47, pat(95, 0));

    // Bank 0 fills on the same edge bank 1 is released.
    for (int k = 96; k < 144; k++) write_one(pat(k, 0), k == 143);
    wr_valid = 1'b0;
    check("band_ready_coincident", 32'(band_ready), 1);
    check("wr_ready_coincident", 32'(wr_ready), 1);
    read_chk(0, pat(96, 0));
    read_chk(1, pat(97, 0));
    read_chk(47, pat(143, 0));

    for (int k = 144; k < 576; k++) begin
      write_one(pat(k, 0), (k % 48) == 0);
      if (k == 574) check("write_complete_w575", 32'(write_complete), 0);
    end
    wr_valid = 1'b0;
    check("write_complete_w576", 32'(write_complete), 1);
    check("wr_ready_drain", 32'(wr_ready), 0);
    check("band_ready_last", 32'(band_ready), 1);
    check("map_done_before", 32'(map_done), 0);
    read_chk(0, pat(528, 0));
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    check("map_done_pulse", 32'(map_done), 1);
    check("band_ready_after_map", 32'(band_ready), 0);
    check("write_complete_idle", 32'(write_complete), 0);
    tick();
    check("map_done_one_cycle", 32'(map_done), 0);
    check("wr_ready_idle_end", 32'(wr_ready), 0);

    // Reset in the middle of FILL.
    pulse_start();
    check("band_ready_restart", 32'(band_ready), 0);
    for (int k = 0; k < 30; k++) write_one(pat(k, 77), 1'b0);
    wr_valid = 1'b0;
    check("wr_ready_pre_rst", 32'(wr_ready), 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_wr_ready", 32'(wr_ready), 0);
    check("midrst_band_ready", 32'(band_ready), 0);
    check("midrst_write_complete", 32'(write_complete), 0);
    check("midrst_map_done", 32'(map_done), 0);
    check("midrst_err_overflow", 32'(err_overflow), 0);
    check("midrst_rd_data", 32'(rd_data), 0);
`ifdef LINE_BUF_STATS_EN
    check("midrst_stall_cycles", 32'(stall_cycles), 0);
`endif
    tick();
    rst = 1'b1;
    tick();
    pulse_start();
    for (int k = 0; k < 48; k++) begin
      write_one(pat(k, 77), 1'b0);
      if (k == 46) check("fresh_band_w47", 32'(band_ready), 0);
    end
    wr_valid = 1'b0;
    check("fresh_band_w48", 32'(band_ready), 1);
    read_chk(0, pat(0, 77));
    read_chk(29, pat(29, 77));
    read_chk(47, pat(47, 77));

    repeat (3) tick();
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rd_pending: got %0d outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
